// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus for the data memory arbiter: one instance per requester port.
// Handshake: a requester raises req with write/addr/wdata and holds all of them stable until grant is seen high in the same cycle;
// grant high means the access is performed on that cycle's clock edge; rvalid pulses for one cycle with rdata on the cycle after a granted read.
interface data_mem_arbiter_if #(
    parameter int ADDRESS_LINE = 8
);
    logic                    req;
    logic                    write;
    logic [ADDRESS_LINE-1:0] addr;
    logic [7:0]              wdata;
    logic                    grant;
    logic [7:0]              rdata;
    logic                    rvalid;

    modport master (output req, write, addr, wdata, input grant, rdata, rvalid);
    modport slave  (input req, write, addr, wdata, output grant, rdata, rvalid);
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares the single-port 8-bit data memory between the core MEM stage and the DMA loader.
// Core has fixed priority; a saturating starvation counter forces a DMA grant after STARVE_LIMIT denied cycles.
module data_mem_arbiter #(
    parameter int ADDRESS_LINE = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    data_mem_arbiter_if.slave       core,
    data_mem_arbiter_if.slave       dma,
    output logic                    core_stall,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic [7:0]              mem_write_data,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [7:0]              mem_read_data,
    output logic [7:0]              starve_cnt
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic force_dma;
    logic core_gnt;
    logic dma_gnt;

    // Grants are gated by reset so nothing reaches the memory while reset is held.
    always_comb begin
        force_dma      = (starve_cnt == LIMIT);
        dma_gnt        = ~reset & dma.req & (~core.req | force_dma);
        core_gnt       = ~reset & core.req & ~dma_gnt;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (dma_gnt) begin
            mem_address    = dma.addr;
            mem_write_data = dma.wdata;
            mem_write      = dma.write;
            mem_read       = ~dma.write;
        end else if (core_gnt) begin
            mem_address    = core.addr;
            mem_write_data = core.wdata;
            mem_write      = core.write;
            mem_read       = ~core.write;
        end
    end

    assign core.grant = core_gnt;
    assign dma.grant  = dma_gnt;
    assign core_stall = ~reset & core.req & ~core_gnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt  <= '0;
            core.rdata  <= '0;
            core.rvalid <= 1'b0;
            dma.rdata   <= '0;
            dma.rvalid  <= 1'b0;
        end else begin
            core.rvalid <= core_gnt & ~core.write;
            dma.rvalid  <= dma_gnt & ~dma.write;
            if (core_gnt && !core.write) core.rdata <= mem_read_data;
            if (dma_gnt && !dma.write)   dma.rdata  <= mem_read_data;
            // Counts only cycles where DMA is asking and losing; any grant or idle cycle restarts it.
            if (dma.req && !dma_gnt) begin
                if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: vector table for single-cycle behaviour plus
// hand-written sequences for starvation forcing and asynchronous reset.
module tb_data_mem_arbiter;

  logic       clock;
  logic       reset;
  logic       core_stall;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_read_data;
  logic [7:0] starve_cnt;

  int n_cmp;
  int n_err;

  data_mem_arbiter_if #(.ADDRESS_LINE(8)) core_bus ();
  data_mem_arbiter_if #(.ADDRESS_LINE(8)) dma_bus ();

  data_mem_arbiter #(.ADDRESS_LINE(8), .STARVE_LIMIT(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .core           (core_bus.slave),
    .dma            (dma_bus.slave),
    .core_stall     (core_stall),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .starve_cnt     (starve_cnt)
  );

  // clock / reset block and data memory model
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] mem [256];
  assign mem_read_data = mem[mem_address];
  always @(posedge clock) if (mem_write) mem[mem_address] <= mem_write_data;

  typedef struct {
    logic       creq;
    logic       cw;
    logic [7:0] ca;
    logic [7:0] cd;
    logic       dreq;
    logic       dw;
    logic [7:0] da;
    logic [7:0] dd;
    logic       cg;
    logic       dg;
    logic       cs;
    logic [7:0] ma;
    logic [7:0] md;
    logic       mw;
    logic       mr;
    logic       crv;
    logic [7:0] crd;
    logic       drv;
    logic [7:0] drd;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic creq, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic dreq, input logic dw, input logic [7:0] da, input logic [7:0] dd);
    core_bus.req   = creq;
    core_bus.write = cw;
    core_bus.addr  = ca;
    core_bus.wdata = cd;
    dma_bus.req    = dreq;
    dma_bus.write  = dw;
    dma_bus.addr   = da;
    dma_bus.wdata  = dd;
  endtask

  task automatic check_vec(input vec_t v, input int k);
    check($sformatf("v%0d core_grant", k), {7'd0, core_bus.grant}, {7'd0, v.cg});
    check($sformatf("v%0d dma_grant", k), {7'd0, dma_bus.grant}, {7'd0, v.dg});
    check($sformatf("v%0d core_stall", k), {7'd0, core_stall}, {7'd0, v.cs});
    check($sformatf("v%0d mem_address", k), mem_address, v.ma);
    check($sformatf("v%0d mem_write_data", k), mem_write_data, v.md);
    check($sformatf("v%0d mem_write", k), {7'd0, mem_write}, {7'd0, v.mw});
    check($sformatf("v%0d mem_read", k), {7'd0, mem_read}, {7'd0, v.mr});
    check($sformatf("v%0d core_rvalid", k), {7'd0, core_bus.rvalid}, {7'd0, v.crv});
    check($sformatf("v%0d core_rdata", k), core_bus.rdata, v.crd);
    check($sformatf("v%0d dma_rvalid", k), {7'd0, dma_bus.rvalid}, {7'd0, v.drv});
    check($sformatf("v%0d dma_rdata", k), dma_bus.rdata, v.drd);
    check($sformatf("v%0d starve_cnt", k), starve_cnt, v.cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //            creq cw  ca     cd     dreq dw  da     dd     cg  dg  cs  ma     md     mw  mr  crv crd    drv drd    cnt
    vecs[0]  = '{1'b1,1'b1,8'h10,8'hA5, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h10,8'hA5,1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 8'd0};
    vecs[1]  = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h10,8'h00,1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 8'd0};
    vecs[2]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h20,8'h3C, 1'b0,1'b1,1'b0,8'h20,8'h3C,1'b1,1'b0, 1'b1,8'hA5, 1'b0,8'h00, 8'd0};
    vecs[3]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h20,8'h00, 1'b0,1'b1,1'b0,8'h20,8'h00,1'b0,1'b1, 1'b0,8'hA5, 1'b0,8'h00, 8'd0};
    vecs[4]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0, 1'b0,8'hA5, 1'b1,8'h3C, 8'd0};
    vecs[5]  = '{1'b1,1'b1,8'h01,8'h11, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h11,1'b1,1'b0, 1'b0,8'hA5, 1'b0,8'h3C, 8'd0};
    vecs[6]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h02,8'h22, 1'b0,1'b1,1'b0,8'h02,8'h22,1'b1,1'b0, 1'b0,8'hA5, 1'b0,8'h3C, 8'd0};
    vecs[7]  = '{1'b1,1'b0,8'h01,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h00,1'b0,1'b1, 1'b0,8'hA5, 1'b0,8'h3C, 8'd0};
    vecs[8]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b0,8'h02,8'h00,1'b0,1'b1, 1'b1,8'h11, 1'b0,8'h3C, 8'd0};
    vecs[9]  = '{1'b1,1'b0,8'h01,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h00,1'b0,1'b1, 1'b0,8'h11, 1'b1,8'h22, 8'd0};
    vecs[10] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b0,8'h02,8'h00,1'b0,1'b1, 1'b1,8'h11, 1'b0,8'h22, 8'd0};
    vecs[11] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h11, 1'b1,8'h22, 8'd0};
    vecs[12] = '{1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h00,1'b0,1'b1, 1'b0,8'h11, 1'b0,8'h22, 8'd0};
    vecs[13] = '{1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h00,1'b0,1'b1, 1'b1,8'h11, 1'b0,8'h22, 8'd1};
    vecs[14] = '{1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h00,1'b0,1'b1, 1'b1,8'h11, 1'b0,8'h22, 8'd2};
    vecs[15] = '{1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h00,1'b0,1'b1, 1'b1,8'h11, 1'b0,8'h22, 8'd3};
    vecs[16] = '{1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b1,8'h02,8'h00,1'b0,1'b1, 1'b1,8'h11, 1'b0,8'h22, 8'd4};
    vecs[17] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h11, 1'b1,8'h22, 8'd0};

    // reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    check("rst core_rvalid", {7'd0, core_bus.rvalid}, 8'd0);
    check("rst dma_rvalid", {7'd0, dma_bus.rvalid}, 8'd0);
    check("rst starve_cnt", starve_cnt, 8'd0);
    check("rst core_rdata", core_bus.rdata, 8'h00);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // table-driven vectors
    for (int k = 0; k < 18; k++) begin
      @(negedge clock);
      drive(vecs[k].creq, vecs[k].cw, vecs[k].ca, vecs[k].cd,
            vecs[k].dreq, vecs[k].dw, vecs[k].da, vecs[k].dd);
      #1;
      check_vec(vecs[k], k);
    end

    // continuous contention: dma forced every 5th cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
      #1;
      check($sformatf("pat%0d dma_grant", i), {7'd0, dma_bus.grant}, (i % 5 == 4) ? 8'd1 : 8'd0);
      check($sformatf("pat%0d core_grant", i), {7'd0, core_bus.grant}, (i % 5 == 4) ? 8'd0 : 8'd1);
      check($sformatf("pat%0d core_stall", i), {7'd0, core_stall}, (i % 5 == 4) ? 8'd1 : 8'd0);
      check($sformatf("pat%0d starve_cnt", i), starve_cnt, 8'(i % 5));
    end

    // dma drops req after 3 denied cycles: counter restarts, full wait again
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
      #1;
      check($sformatf("drop%0d dma_grant", i), {7'd0, dma_bus.grant}, 8'd0);
    end
    @(negedge clock);
    drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h02, 8'h00);
    #1;
    check("drop gap starve_cnt", starve_cnt, 8'd3);
    check("drop gap core_grant", {7'd0, core_bus.grant}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
      #1;
      check($sformatf("rewait%0d starve_cnt", i), starve_cnt, 8'(i));
      check($sformatf("rewait%0d dma_grant", i), {7'd0, dma_bus.grant}, (i == 4) ? 8'd1 : 8'd0);
    end

    // asynchronous reset in the middle of a granted core read
    @(negedge clock);
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    #1;
    check("arst pre core_grant", {7'd0, core_bus.grant}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst core_grant", {7'd0, core_bus.grant}, 8'd0);
    check("arst dma_grant", {7'd0, dma_bus.grant}, 8'd0);
    check("arst mem_read", {7'd0, mem_read}, 8'd0);
    check("arst mem_write", {7'd0, mem_write}, 8'd0);
    check("arst core_stall", {7'd0, core_stall}, 8'd0);
    check("arst starve_cnt", starve_cnt, 8'd0);
    check("arst core_rdata", core_bus.rdata, 8'h00);
    check("arst dma_rdata", dma_bus.rdata, 8'h00);
    @(posedge clock);
    #1;
    check("arst held core_rvalid", {7'd0, core_bus.rvalid}, 8'd0);
    check("arst held starve_cnt", starve_cnt, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    check("arst rel core_rvalid", {7'd0, core_bus.rvalid}, 8'd0);
    @(negedge clock);
    #1;
    check("arst post core_rvalid", {7'd0, core_bus.rvalid}, 8'd0);
    check("arst post starve_cnt", starve_cnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
